// File: rtl/mskaes_ctrl_pkg.sv
// Purpose : shared types for the masked AES round controller (FSM states, key-length codes, round count).
// Latency : n/a (types and a pure function only).
// Backpr. : n/a.
package mskaes_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ROUND      = 2'd1,
        ST_LAST_ROUND = 2'd2,
        ST_OUT_HOLD   = 2'd3
    } state_e;

    localparam logic [1:0] KEY_LEN_128  = 2'd0;
    localparam logic [1:0] KEY_LEN_192  = 2'd1;
    localparam logic [1:0] KEY_LEN_256  = 2'd2;
    localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

    // Number of AES rounds for a key-length code; the reserved code falls back to AES-128.
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_192: nr_of = 4'd12;
            KEY_LEN_256: nr_of = 4'd14;
            default:     nr_of = 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/mskaes_ctrl_cnt.sv
// Purpose : up-counter with synchronous clear (wins over increment) and asynchronous active-low reset.
// Latency : count visible one cycle after i_inc/i_clr.
// Backpr. : none; ports: clk, nrst, i_clr, i_inc -> o_cnt[WIDTH-1:0].
module mskaes_ctrl_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mskaes_ctrl_fsm_multikey.sv
// Purpose : control FSM of the masked round-based AES core (128/192/256-bit keys, parametrised S-box latency).
// Latency : fetch at cycle 0 -> cipher_valid at cycle NR*(SBOX_LAT+1)+1; all outputs are combinational decodes.
// Backpr. : result held in OUT_HOLD until out_ready; ready only in IDLE; flush aborts to IDLE from any state.
// Ports   : in  clk, nrst, valid_in, key_len[1:0], out_ready, flush
//           out ready, cipher_valid, busy, feed_in, state_reg_enable, state_mux_lastR, key_reg_enable,
//               SB_valid_in, KS_in_valid, KS_rcon_update, KS_rcon_rst, rnd_idx[3:0], key_len_q[1:0]
module mskaes_ctrl_fsm_multikey
    import mskaes_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = 6,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       valid_in,
    input  logic [1:0] key_len,
    input  logic       out_ready,
    input  logic       flush,
    output logic       ready,
    output logic       cipher_valid,
    output logic       busy,
    output logic       feed_in,
    output logic       state_reg_enable,
    output logic       state_mux_lastR,
    output logic       key_reg_enable,
    output logic       SB_valid_in,
    output logic       KS_in_valid,
    output logic       KS_rcon_update,
    output logic       KS_rcon_rst,
    output logic [3:0] rnd_idx,
    output logic [1:0] key_len_q
);

    generate
        if (SBOX_LAT < 1 || SBOX_LAT > (2**CNT_W) - 1) begin : g_lat_chk
            $error("SBOX_LAT must be in 1..2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(SBOX_LAT);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [1:0]       r_key_len_q;
    logic [CNT_W-1:0] w_cnt_fsm;
    logic [3:0]       w_rnd_idx;
    logic [3:0]       w_nr;
    logic             w_end_rnd;
    logic             w_fetch;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_rnd_clr;
    logic             w_rnd_inc;

    mskaes_ctrl_cnt #(.WIDTH(CNT_W)) u_cnt_fsm (
        .clk   (clk),
        .nrst  (nrst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_cnt (w_cnt_fsm)
    );

    mskaes_ctrl_cnt #(.WIDTH(4)) u_rnd_idx (
        .clk   (clk),
        .nrst  (nrst),
        .i_clr (w_rnd_clr),
        .i_inc (w_rnd_inc),
        .o_cnt (w_rnd_idx)
    );

    assign w_nr      = nr_of(r_key_len_q);
    assign w_end_rnd = (w_cnt_fsm == LP_CNT_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_key_len_q <= KEY_LEN_128;
        end else begin
            r_state <= w_state_nxt;
            if (w_fetch) begin
                // The reserved code is folded to AES-128 so the schedule never sees it.
                r_key_len_q <= (key_len == KEY_LEN_RSVD) ? KEY_LEN_128 : key_len;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch          = 1'b0;
        w_cnt_clr        = 1'b0;
        w_cnt_inc        = 1'b0;
        w_rnd_clr        = 1'b0;
        w_rnd_inc        = 1'b0;
        ready            = 1'b0;
        cipher_valid     = 1'b0;
        busy             = 1'b0;
        feed_in          = 1'b0;
        state_reg_enable = 1'b0;
        state_mux_lastR  = 1'b0;
        key_reg_enable   = 1'b0;
        SB_valid_in      = 1'b0;
        KS_in_valid      = 1'b0;
        KS_rcon_update   = 1'b0;
        KS_rcon_rst      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Registers keep loading the external input while idle; ready drops during
                // flush so a producer never sees a handshake that the FSM discards.
                ready            = !flush;
                feed_in          = 1'b1;
                state_reg_enable = 1'b1;
                key_reg_enable   = 1'b1;
                if (flush) begin
                    w_cnt_clr = 1'b1;
                    w_rnd_clr = 1'b1;
                end else if (valid_in) begin
                    KS_rcon_rst = 1'b1;
                    w_fetch     = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_rnd_clr   = 1'b1;
                    w_state_nxt = ST_ROUND;
                end
            end

            ST_ROUND, ST_LAST_ROUND: begin
                busy = 1'b1;
                if (flush) begin
                    w_cnt_clr   = 1'b1;
                    w_rnd_clr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (w_cnt_fsm == '0) begin
                        SB_valid_in = 1'b1;
                        KS_in_valid = 1'b1;
                    end
                    if (w_end_rnd) begin
                        state_reg_enable = 1'b1;
                        key_reg_enable   = 1'b1;
                        KS_rcon_update   = 1'b1;
                        w_rnd_inc        = 1'b1;
                        w_cnt_clr        = 1'b1;
                        if (r_state == ST_LAST_ROUND) begin
                            state_mux_lastR = 1'b1;
                            w_state_nxt     = ST_OUT_HOLD;
                        end else if (w_rnd_idx == w_nr - 4'd2) begin
                            w_state_nxt = ST_LAST_ROUND;
                        end
                    end
                end
            end

            ST_OUT_HOLD: begin
                if (flush) begin
                    w_cnt_clr   = 1'b1;
                    w_rnd_clr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    cipher_valid = 1'b1;
                    if (out_ready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    assign rnd_idx   = w_rnd_idx;
    assign key_len_q = r_key_len_q;

endmodule
